// File: rtl/uart_cmd_rcvr.sv
// uart_cmd_rcvr: 8N1 UART receiver that pairs two bytes into a 16-bit command.
// The first byte received becomes cmd[15:8] and the second becomes cmd[7:0]. cmd_rdy is
// sticky until the consumer acknowledges it. A framing error resynchronizes the byte pairing.
module uart_cmd_rcvr #(
    parameter int unsigned BAUD_CYCLES = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err
);

    localparam int unsigned CntW = $clog2(BAUD_CYCLES);
    localparam logic [CntW-1:0] HalfLoad = CntW'(BAUD_CYCLES / 2);
    localparam logic [CntW-1:0] FullLoad = CntW'(BAUD_CYCLES - 1);

    typedef enum logic {RxIdle, RxShift} rx_state_e;
    typedef enum logic {WaitHi, WaitLo} asm_state_e;

    rx_state_e       rx_state_q, rx_state_d;
    asm_state_e      asm_state_q, asm_state_d;
    logic            rx_meta_q, rx_s_q;
    logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [7:0]      hi_byte_q, hi_byte_d;
    logic [15:0]     cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;

    logic       rx_s;
    logic       baud_tick, first_sample, last_sample;
    logic       start_det, byte_vld;
    logic [7:0] rx_byte;
    logic       unused_start_bit;

    assign rx_s = rx_s_q;

    // Two-flop synchronizer; preset high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State and datapath registers for both state machines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= RxIdle;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            asm_state_q <= WaitHi;
            hi_byte_q   <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            asm_state_q <= asm_state_d;
            hi_byte_q   <= hi_byte_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
        end
    end

    // Sample-point decode shared by the next-state and output logic.
    always_comb begin
        baud_tick    = (rx_state_q == RxShift) && (baud_cnt_q == '0);
        first_sample = baud_tick && (bit_cnt_q == 4'd0);
        last_sample  = baud_tick && (bit_cnt_q == 4'd9);
    end

    // Bit receiver next state: half-bit delay to mid start bit, then one sample per bit.
    always_comb begin
        rx_state_d = rx_state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_s) begin
                    rx_state_d = RxShift;
                    baud_cnt_d = HalfLoad;
                    bit_cnt_d  = '0;
                end
            end
            RxShift: begin
                if (baud_tick) begin
                    shift_d    = {rx_s, shift_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    baud_cnt_d = FullLoad;
                    // A high mid-start sample is a glitch; the stop sample ends the frame.
                    if ((first_sample && rx_s) || last_sample) begin
                        rx_state_d = RxIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - CntW'(1);
                end
            end
        endcase
    end

    // Receiver outputs: byte strobe, framing error and start detection.
    always_comb begin
        byte_vld  = last_sample && rx_s;
        frm_err   = last_sample && !rx_s;
        start_det = (rx_state_q == RxIdle) && !rx_s;
        // On the stop sample the post-shift shift[8:1] equals the pre-shift shift[9:2].
        rx_byte   = shift_q[9:2];
    end

    // The start bit ends up in shift[0] and is never needed.
    assign unused_start_bit = shift_q[0];

    // Frame assembler next state: pair bytes into a command; a framing error restarts pairing.
    always_comb begin
        asm_state_d = asm_state_q;
        hi_byte_d   = hi_byte_q;
        cmd_d       = cmd_q;
        if (frm_err) begin
            asm_state_d = WaitHi;
        end else if (byte_vld) begin
            unique case (asm_state_q)
                WaitHi: begin
                    hi_byte_d   = rx_byte;
                    asm_state_d = WaitLo;
                end
                WaitLo: begin
                    cmd_d       = {hi_byte_q, rx_byte};
                    asm_state_d = WaitHi;
                end
            endcase
        end
    end

    // Sticky ready flag: a completed pair wins over an acknowledge or a new-command start.
    always_comb begin
        cmd_rdy_d = cmd_rdy_q;
        if (byte_vld && (asm_state_q == WaitLo)) begin
            cmd_rdy_d = 1'b1;
        end else if (clr_cmd_rdy || (start_det && (asm_state_q == WaitHi))) begin
            cmd_rdy_d = 1'b0;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_rcvr.sv
// Testbench for uart_cmd_rcvr. The expected command is queued when a pair is sent, and a
// monitor pops and compares it when cmd_rdy rises.
module tb_uart_cmd_rcvr;

    localparam int unsigned Baud = 16;
    // Start-bit drive to cmd_rdy visible: 2 sync + 1 detect + Baud/2 + 9*Baud + 1 register.
    localparam int RdyLat = 3 + (Baud / 2) + 9 * Baud + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          frm_cnt = 0;
    logic        prev_rdy = 1'b0;
    logic [15:0] exp_cmd;
    logic [15:0] exp_q[$];

    uart_cmd_rcvr #(
        .BAUD_CYCLES(Baud)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .frm_err    (frm_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: compare the command and the latency on each cmd_rdy rise.
    initial forever begin
        @(negedge clk);
        if (frm_err) frm_cnt++;
        if (cmd_rdy && !prev_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: cmd_rdy rose with cmd=%h, none expected", cmd);
            end else begin
                exp_cmd = exp_q.pop_front();
                checks++;
                if (cmd !== exp_cmd) begin
                    errors++;
                    $display("FAIL cmd_value: got %h expected %h", cmd, exp_cmd);
                end
                checks++;
                if ((cyc - start_cyc) !== RdyLat) begin
                    errors++;
                    $display("FAIL rdy_latency: got %0d expected %0d", cyc - start_cyc, RdyLat);
                end
            end
        end
        prev_rdy = cmd_rdy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Send one 8N1 frame starting at a negedge; returns on a negedge.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int idle_bits);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (Baud) @(negedge clk);
        end
        RX = 1'b1;
        repeat (idle_bits * Baud) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd !== 16'h0000) begin
            errors++; $display("FAIL reset_cmd: got %h expected 0000", cmd);
        end
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_rdy: got %b expected 0", cmd_rdy);
        end
        checks++;
        if (frm_err !== 1'b0) begin
            errors++; $display("FAIL reset_frm_err: got %b expected 0", frm_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int f0;
        f0 = frm_cnt;
        exp_q.push_back(16'hA53C);
        send_byte(8'hA5, 1'b1, 1);
        send_byte(8'h3C, 1'b1, 1);
        checks++;
        if (frm_cnt - f0 !== 0) begin
            errors++; $display("FAIL basic_frm_err: got %0d pulses expected 0", frm_cnt - f0);
        end
    endtask

    task automatic test_ack();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++; $display("FAIL ack_rdy: got %b expected 0", cmd_rdy);
        end
        checks++;
        if (cmd !== 16'hA53C) begin
            errors++; $display("FAIL ack_cmd_hold: got %h expected a53c", cmd);
        end
    endtask

    task automatic test_priority();
        exp_q.push_back(16'h5AC3);
        send_byte(8'h5A, 1'b1, 1);
        fork
            send_byte(8'hC3, 1'b1, 1);
            begin
                // Acknowledge in the very cycle the completed pair sets cmd_rdy.
                repeat (RdyLat - 1) @(posedge clk);
                @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                checks++;
                if (cmd_rdy !== 1'b1) begin
                    errors++; $display("FAIL prio_set_wins: got %b expected 1", cmd_rdy);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(16'h00FF);
        fork
            send_byte(8'h00, 1'b1, 0);
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                checks++;
                if (cmd_rdy !== 1'b1) begin
                    errors++; $display("FAIL b2b_rdy_before_start: got %b expected 1", cmd_rdy);
                end
                @(negedge clk);
                checks++;
                if (cmd_rdy !== 1'b0) begin
                    errors++; $display("FAIL b2b_auto_clear: got %b expected 0", cmd_rdy);
                end
            end
        join
        send_byte(8'hFF, 1'b1, 0);
    endtask

    task automatic test_frm_err();
        int f0;
        f0 = frm_cnt;
        exp_q.push_back(16'h3456);
        send_byte(8'h12, 1'b0, 1);
        send_byte(8'h34, 1'b1, 1);
        send_byte(8'h56, 1'b1, 1);
        checks++;
        if (frm_cnt - f0 !== 1) begin
            errors++; $display("FAIL frm_err_pulses: got %0d expected 1", frm_cnt - f0);
        end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = frm_cnt;
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (cmd !== 16'h3456) begin
            errors++; $display("FAIL glitch_cmd_hold: got %h expected 3456", cmd);
        end
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++; $display("FAIL glitch_rdy_clear: got %b expected 0", cmd_rdy);
        end
        exp_q.push_back(16'hC381);
        send_byte(8'hC3, 1'b1, 1);
        send_byte(8'h81, 1'b1, 1);
        checks++;
        if (frm_cnt - f0 !== 0) begin
            errors++; $display("FAIL glitch_frm_err: got %0d pulses expected 0", frm_cnt - f0);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] frame;
        send_byte(8'h77, 1'b1, 1);
        // Low byte: start plus d0..d3 in full, then reset halfway through d4.
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 5; i++) begin
            RX = frame[i];
            repeat (Baud) @(negedge clk);
        end
        RX = frame[5];
        repeat (Baud / 2) @(negedge clk);
        rst_n = 1'b0;
        RX = 1'b1;
        #1;
        checks++;
        if (cmd !== 16'h0000) begin
            errors++; $display("FAIL midrst_cmd: got %h expected 0000", cmd);
        end
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++; $display("FAIL midrst_rdy: got %b expected 0", cmd_rdy);
        end
        checks++;
        if (frm_err !== 1'b0) begin
            errors++; $display("FAIL midrst_frm_err: got %b expected 0", frm_err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(16'h9ABC);
        send_byte(8'h9A, 1'b1, 1);
        send_byte(8'hBC, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack();
        test_priority();
        test_back_to_back();
        test_frm_err();
        test_glitch();
        test_reset_mid();
        repeat (20) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_cmds: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
